// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read register file with a load scoreboard, RAW hazard flags and write forwarding.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int N_READ     = 3,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_READ-1:0]            rd_en,
    input  logic [N_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [N_READ*DATA_WIDTH-1:0] rd_data,
    output logic [N_READ-1:0]            rd_busy,
    input  logic                         alu_we,
    input  logic [ADDR_WIDTH-1:0]        alu_waddr,
    input  logic [DATA_WIDTH-1:0]        alu_wdata,
    input  logic                         ld_issue,
    input  logic [ADDR_WIDTH-1:0]        ld_issue_addr,
    output logic                         ld_issue_ready,
    input  logic                         ld_wb_valid,
    output logic                         ld_wb_ready,
    input  logic [ADDR_WIDTH-1:0]        ld_wb_addr,
    input  logic [DATA_WIDTH-1:0]        ld_wb_data,
    output logic [2**ADDR_WIDTH-1:0]     busy_vec,
    output logic [ADDR_WIDTH:0]          pending_count,
    output logic                         waw_err,
    output logic                         spur_err
);
    localparam int N_REG = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] regs [N_REG];
    logic [N_REG-1:0]      busy, busy_nxt;
    logic [ADDR_WIDTH:0]   cnt_nxt;
    logic alu_zero, wb_zero, iss_zero, alu_commit, wb_acc, iss_acc;
    assign alu_zero       = (ZERO_REG != 0) && (alu_waddr == '0);
    assign wb_zero        = (ZERO_REG != 0) && (ld_wb_addr == '0);
    assign iss_zero       = (ZERO_REG != 0) && (ld_issue_addr == '0);
    assign alu_commit     = ~reset & alu_we & ~busy[alu_waddr] & ~alu_zero;
    assign ld_issue_ready = ~reset & ~busy[ld_issue_addr];
    assign ld_wb_ready    = ~reset & ~(alu_we & (alu_waddr == ld_wb_addr));
    assign wb_acc         = ld_wb_valid & ld_wb_ready;
    assign iss_acc        = ld_issue & ld_issue_ready & ~iss_zero;
    assign busy_vec       = busy;
    // Writeback clears before issue sets, so a same-address pair leaves the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wb_acc) busy_nxt[ld_wb_addr] = 1'b0;
        if (iss_acc) busy_nxt[ld_issue_addr] = 1'b1;
        cnt_nxt = '0;
        for (int j = 0; j < N_REG; j++) cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[j]};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < N_REG; j++) regs[j] <= '0;
            busy          <= '0;
            pending_count <= '0;
            waw_err       <= 1'b0;
            spur_err      <= 1'b0;
        end else begin
            if (alu_commit) regs[alu_waddr] <= alu_wdata;
            if (wb_acc && !wb_zero) regs[ld_wb_addr] <= ld_wb_data;
            busy          <= busy_nxt;
            pending_count <= cnt_nxt;
            if (alu_we && busy[alu_waddr]) waw_err <= 1'b1;
            if (wb_acc && !wb_zero && !busy[ld_wb_addr]) spur_err <= 1'b1;
        end
    end
    for (genvar i = 0; i < N_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic fwd_alu, fwd_wb, zero_rd;
        assign a       = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero_rd = (ZERO_REG != 0) && (a == '0);
        assign fwd_alu = (BYPASS != 0) && alu_commit && (alu_waddr == a);
        assign fwd_wb  = (BYPASS != 0) && wb_acc && (ld_wb_addr == a);
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = (!rd_en[i] || zero_rd) ? '0 :
                                                     fwd_alu ? alu_wdata :
                                                     fwd_wb  ? ld_wb_data : regs[a];
        assign rd_busy[i] = rd_en[i] & busy[a] & ~fwd_wb;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-read register file for the processor datapath. Generalises the dual-read register to N read ports, configurable width and depth, and two write sources.
- The two write sources are an ALU write port and a RAM-load writeback port with a valid/ready handshake.
- A per-register busy scoreboard tracks in-flight RAM loads, flags RAW hazards on read ports and forwards same-cycle writes.

Parameters:
- DATA_WIDTH, 16, register width in bits
- ADDR_WIDTH, 4, register address width; N_REG = 2**ADDR_WIDTH
- N_READ, 3, number of combinational read ports
- ZERO_REG, 0, 1 = register 0 reads 0, ignores writes, never goes busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rd_en  in  N_READ  per-port read enable
- rd_addr  in  N_READ*ADDR_WIDTH  packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  N_READ*DATA_WIDTH  packed read data
- rd_busy  out  N_READ  operand pending (RAW hazard), consumer must stall
- alu_we  in  1  ALU write enable
- alu_waddr  in  ADDR_WIDTH  ALU destination
- alu_wdata  in  DATA_WIDTH  ALU result
- ld_issue  in  1  RAM load issued to ld_issue_addr
- ld_issue_addr  in  ADDR_WIDTH  load destination register
- ld_issue_ready  out  1  issue accepted this cycle
- ld_wb_valid  in  1  load data available
- ld_wb_ready  out  1  writeback accepted
- ld_wb_addr  in  ADDR_WIDTH  writeback destination
- ld_wb_data  in  DATA_WIDTH  loaded data
- busy_vec  out  N_REG  scoreboard bits
- pending_count  out  ADDR_WIDTH+1  number of set busy bits
- waw_err  out  1  sticky: ALU write to busy register
- spur_err  out  1  sticky: writeback to non-busy register

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high, port name reset.
  - While reset is high: ld_issue_ready=0 and ld_wb_ready=0.
  - On reset: all registers=0, busy_vec=0, pending_count=0, waw_err=0, spur_err=0.
  - Reset mid-operation discards all pending loads. Writebacks arriving after reset are spurious.
- Reads (combinational, zero latency):
  - rd_data[i] = 0 when rd_en[i]=0.
  - Otherwise rd_data[i] = registers[rd_addr[i]], subject to forwarding.
  - Register 0 reads 0 when ZERO_REG=1.
- Forwarding (BYPASS=1):
  - If an ALU write commits to rd_addr[i] this cycle, alu_wdata is forwarded.
  - Else, if a load writeback is accepted to rd_addr[i] this cycle, ld_wb_data is forwarded and rd_busy[i]=0.
  - With BYPASS=0, reads return the pre-edge value.
- Hazard flag: rd_busy[i] = rd_en[i] & busy[rd_addr[i]] & ~(forwarded accepted writeback).
- ALU write:
  - Commits at the clk edge when alu_we=1 and busy[alu_waddr]=0.
  - If alu_we=1 and the target is busy: the write is dropped and waw_err is set.
  - ZERO_REG=1 and address 0: the write is dropped silently.
- Load issue:
  - ld_issue_ready = ~reset & ~busy[ld_issue_addr].
  - Accepted when ld_issue & ld_issue_ready; busy[ld_issue_addr] sets at the next edge.
  - An issue to register 0 with ZERO_REG=1 is accepted but sets no busy bit.
- Writeback handshake:
  - ld_wb_ready = ~reset & ~(alu_we & alu_waddr==ld_wb_addr), i.e. ALU has priority on an address collision.
  - The source holds valid, addr and data stable until ready.
  - On accept: the register is written and busy[ld_wb_addr] is cleared at the edge.
  - If the target was not busy: the write still occurs and spur_err is set, except address 0 with ZERO_REG=1 (dropped, no error).
- Simultaneous events:
  - Issue and writeback to the same address in one cycle: the issue is not ready, because the bit is still busy. It can be accepted in the following cycle.
  - Issue and writeback to different addresses in one cycle: both take effect.
- pending_count is registered and updated with busy_vec. Range 0..N_REG, no wrap.

Test Plan:
- Reset, then read all ports: rd_data=0, busy_vec=0, pending_count=0, errors 0.
- ALU write r3=0x1234 with port0 reading r3 in the same cycle, BYPASS=1 -> port0 shows 0x1234 that cycle and the next; with BYPASS=0 -> 0x0000 then 0x1234.
- Issue load to r5 -> next cycle busy_vec[5]=1, pending_count=1, reads of r5 give rd_busy=1. Second issue to r5 -> ld_issue_ready=0. Writeback r5=0xBEEF -> forwarded, rd_busy=0, busy clears, pending_count=0.
- Writeback valid to r7 while alu_we to r7 with 0x0001 -> ld_wb_ready=0, r7=0x0001. Next cycle accepted -> r7=load data, spur_err=1, since r7 was not busy.
- Issue r2, then alu_we r2=0xAAAA -> r2 unchanged, waw_err=1 and stays set until reset.
- ZERO_REG=1: write r0=0xFFFF and issue a load to r0 -> r0 reads 0, busy_vec[0]=0. Reset asserted with 3 loads pending -> busy_vec=0, ready outputs low while reset is high.
